// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store controller.
// Opcodes, funct3 codes, byte-enable base patterns and FSM states.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [3:0] {
        BE_SB = 4'b0001,
        BE_SH = 4'b0011,
        BE_SW = 4'b1111
    } be_base_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/lsu_if.sv
// Execute-side, data-memory and writeback signals of the load/store controller.
// master is the controller's view; slave is the surrounding pipeline and memory.
interface lsu_if;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;

    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [31:0] wb_data;
    logic        wb_err;

    modport master (
        input  ex_valid, ex_instr, ex_addr, ex_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output ex_ready,
        output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        output wb_valid, wb_data, wb_err
    );

    modport slave (
        output ex_valid, ex_instr, ex_addr, ex_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  ex_ready,
        input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
        input  wb_valid, wb_data, wb_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction
// and legality/alignment decode for one access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic        is_load;
    logic        is_store;
    logic [15:0] shifted;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign shifted  = 16'(rdata >> {addr_lo, 3'b000});

    always_comb begin
        // NOTE: every output gets a default first, so no path through the cases infers a latch.
        be         = '0;
        wdata_rep  = wdata;
        rdata_ext  = '0;
        misaligned = 1'b0;
        illegal    = 1'b1;

        case (funct3[1:0])
            2'b00: begin
                be        = 4'(BE_SB) << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'(BE_SH) << addr_lo;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                be         = BE_SW;
                misaligned = |addr_lo;
            end
            default: ;
        endcase

        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'b0, shifted[7:0]};
            F3_HU:   rdata_ext = {16'b0, shifted};
            default: ;
        endcase

        // Loads always fetch the whole word and pick lanes on the way back.
        if (is_load) begin
            be      = BE_SW;
            illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else if (is_store) begin
            illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer: op latch, REQ/WAIT/DONE FSM with
// registered outputs, and a gnt/rvalid timeout counter.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.master bus,
    output logic  busy
);

    localparam bit               TO_EN   = (RSP_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RSP_TIMEOUT - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       op_opcode;
    logic [2:0]       op_funct3;
    logic [1:0]       op_addr_lo;

    logic             idle;
    logic             timeout_hit;
    logic [6:0]       al_opcode;
    logic [2:0]       al_funct3;
    logic [1:0]       al_addr_lo;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;
    logic             al_misaligned;
    logic             al_illegal;
    logic             unused_instr;

    // The lane logic decodes the incoming op while idle and the latched op afterwards.
    assign idle         = (state == S_IDLE);
    assign al_opcode    = idle ? bus.ex_instr[6:0]   : op_opcode;
    assign al_funct3    = idle ? bus.ex_instr[14:12] : op_funct3;
    assign al_addr_lo   = idle ? bus.ex_addr[1:0]    : op_addr_lo;
    assign timeout_hit  = TO_EN && (cnt == TO_LAST);
    assign unused_instr = ^{bus.ex_instr[31:15], bus.ex_instr[11:7]};

    lsu_align u_align (
        .opcode     (al_opcode),
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .wdata      (bus.ex_wdata),
        .rdata      (bus.mem_rdata),
        .be         (al_be),
        .wdata_rep  (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            op_opcode     <= '0;
            op_funct3     <= '0;
            op_addr_lo    <= '0;
            busy          <= 1'b0;
            bus.ex_ready  <= 1'b1;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            bus.wb_valid  <= 1'b0;
            bus.wb_data   <= '0;
            bus.wb_err    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (bus.ex_valid) begin
                    busy         <= 1'b1;
                    bus.ex_ready <= 1'b0;
                    op_opcode    <= bus.ex_instr[6:0];
                    op_funct3    <= bus.ex_instr[14:12];
                    op_addr_lo   <= bus.ex_addr[1:0];
                    if (al_illegal || al_misaligned) begin
                        state        <= S_DONE;
                        bus.wb_valid <= 1'b1;
                        bus.wb_err   <= 1'b1;
                        bus.wb_data  <= '0;
                    end else begin
                        state         <= S_REQ;
                        cnt           <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_addr  <= {bus.ex_addr[31:2], 2'b00};
                        bus.mem_we    <= (bus.ex_instr[6:0] == OP_STORE);
                        bus.mem_be    <= al_be;
                        bus.mem_wdata <= al_wdata;
                    end
                end
                S_REQ: if (bus.mem_gnt) begin
                    bus.mem_req <= 1'b0;
                    if (op_opcode != OP_LOAD || bus.mem_rvalid) begin
                        state        <= S_DONE;
                        bus.wb_valid <= 1'b1;
                        bus.wb_err   <= 1'b0;
                        bus.wb_data  <= (op_opcode == OP_LOAD) ? al_rdata : '0;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end else if (timeout_hit) begin
                    state        <= S_DONE;
                    bus.mem_req  <= 1'b0;
                    bus.wb_valid <= 1'b1;
                    bus.wb_err   <= 1'b1;
                    bus.wb_data  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_WAIT: if (bus.mem_rvalid) begin
                    state        <= S_DONE;
                    bus.wb_valid <= 1'b1;
                    bus.wb_err   <= 1'b0;
                    bus.wb_data  <= al_rdata;
                end else if (timeout_hit) begin
                    state        <= S_DONE;
                    bus.wb_valid <= 1'b1;
                    bus.wb_err   <= 1'b1;
                    bus.wb_data  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    bus.ex_ready <= 1'b1;
                    bus.wb_valid <= 1'b0;
                    bus.wb_err   <= 1'b0;
                    bus.wb_data  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written reset and
// timeout sequences, and randomized ops scored against a byte-level reference model.
module tb_lsu_ctrl;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    lsu_if bus ();

    lsu_ctrl #(.RSP_TIMEOUT(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, addr, wdata, rdata;
        int          gnt_dly, rv_dly;
        bit          no_gnt, no_rv;
        int          e_cyc;
        bit          e_err;
        logic [31:0] e_data;
        bit          e_req;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        bit          e_we;
        int          e_reqc;
    } vec_t;

    typedef struct {
        int          wb_cyc;
        bit          saw_req;
        logic [31:0] m_addr;
        logic [3:0]  m_be;
        logic [31:0] m_wdata;
        bit          m_we;
        bit          err;
        logic [31:0] data;
        int          req_cycles;
        bit          proto_bad;
        bit          post_valid;
        bit          post_ready;
    } res_t;

    typedef struct {
        bit          err;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
        return {17'b0, f3, 5'b0, op};
    endfunction

    // Byte-level reference: access size, lane offset and extension from the ISA rules.
    function automatic exp_t model(input logic [31:0] instr, addr, wdata, rdata);
        exp_t        e;
        int          size;
        int          off;
        bit          is_ld, is_st, legal;
        logic [31:0] mask, v;
        logic [2:0]  f3;
        f3    = instr[14:12];
        off   = int'(addr[1:0]);
        is_ld = (instr[6:0] == LD);
        is_st = (instr[6:0] == ST);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) :
                is_st ? (f3 <= 3'd2) : 1'b0;
        e.err = !legal || ((off % size) != 0);
        e.we  = is_st;
        e.be  = is_ld ? 4'hF : 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        v    = (rdata >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        e.data = (is_ld && !e.err) ? v : 32'd0;
        return e;
    endfunction

    // Presents one op at the current cycle (cycle 0) and plays the memory side.
    task automatic do_op(input logic [31:0] instr, addr, wdata, rdata,
                         input int gnt_dly, rv_dly, input bit no_gnt, no_rv,
                         output res_t r);
        int req_seen, since_gnt;
        bit granted, done;
        r        = '{default: 0};
        r.wb_cyc = -1;
        if (bus.ex_ready !== 1'b1) r.proto_bad = 1;
        bus.ex_valid = 1'b1;
        bus.ex_instr = instr;
        bus.ex_addr  = addr;
        bus.ex_wdata = wdata;
        step();
        bus.ex_valid = 1'b0;
        bus.ex_instr = $urandom;
        bus.ex_addr  = $urandom;
        bus.ex_wdata = $urandom;
        req_seen = 0; since_gnt = 0; granted = 0; done = 0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
            if (bus.wb_valid === 1'b1) begin
                r.wb_cyc = cyc;
                r.err    = bus.wb_err;
                r.data   = bus.wb_data;
                done     = 1;
            end else begin
                if (bus.ex_ready !== 1'b0 || busy !== 1'b1) r.proto_bad = 1;
                if (bus.mem_req === 1'b1) begin
                    if (!r.saw_req) begin
                        r.saw_req = 1;
                        r.m_addr  = bus.mem_addr;
                        r.m_be    = bus.mem_be;
                        r.m_wdata = bus.mem_wdata;
                        r.m_we    = bus.mem_we;
                    end else if (bus.mem_addr !== r.m_addr || bus.mem_be !== r.m_be ||
                                 bus.mem_wdata !== r.m_wdata || bus.mem_we !== r.m_we) begin
                        r.proto_bad = 1;
                    end
                    r.req_cycles++;
                    if (!no_gnt && req_seen == gnt_dly) begin
                        bus.mem_gnt = 1'b1;
                        granted     = 1;
                    end else begin
                        bus.mem_rvalid = 1'($urandom_range(0, 1));
                    end
                    req_seen++;
                end
                if (granted && !r.m_we && !no_rv && since_gnt == rv_dly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                end
                step();
                if (granted) since_gnt++;
            end
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (done) begin
            step();
            r.post_valid = bus.wb_valid;
            r.post_ready = bus.ex_ready;
        end
    endtask

    task automatic verify(input string t, input vec_t v, input res_t r);
        check({t, ".wb_cycle"}, r.wb_cyc, v.e_cyc);
        check({t, ".wb_err"}, r.err, v.e_err);
        check({t, ".wb_data"}, r.data, v.e_data);
        check({t, ".mem_req_seen"}, r.saw_req, v.e_req);
        check({t, ".req_cycles"}, r.req_cycles, v.e_reqc);
        check({t, ".protocol_ok"}, r.proto_bad, 0);
        check({t, ".wb_pulse_width"}, r.post_valid, 0);
        check({t, ".ready_after"}, r.post_ready, 1);
        if (v.e_req) begin
            check({t, ".mem_addr"}, r.m_addr, v.e_addr);
            check({t, ".mem_be"}, r.m_be, v.e_be);
            check({t, ".mem_we"}, r.m_we, v.e_we);
            if (v.e_we) check({t, ".mem_wdata"}, r.m_wdata, v.e_wdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        vec_t v;
        exp_t e;

        // instr, addr, wdata, rdata, gnt_dly, rv_dly, no_gnt, no_rv,
        // e_cyc, e_err, e_data, e_req, e_addr, e_be, e_wdata, e_we, e_reqc
        vecs[0]  = '{enc(ST, 3'd0), 32'h1003, 32'hAABBCC5A, 32'h0, 0, 0, 0, 0,
                     2, 0, 32'h0, 1, 32'h1000, 4'b1000, 32'h5A5A5A5A, 1, 1};
        vecs[1]  = '{enc(LD, 3'd1), 32'h2002, 32'h0, 32'h80011234, 3, 3, 0, 0,
                     8, 0, 32'hFFFF8001, 1, 32'h2000, 4'hF, 32'h0, 0, 4};
        vecs[2]  = '{enc(LD, 3'd5), 32'h2002, 32'h0, 32'h80011234, 3, 3, 0, 0,
                     8, 0, 32'h00008001, 1, 32'h2000, 4'hF, 32'h0, 0, 4};
        vecs[3]  = '{enc(LD, 3'd2), 32'h3001, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[4]  = '{enc(LD, 3'd0), 32'h0, 32'h0, 32'h000000F0, 0, 0, 0, 0,
                     2, 0, 32'hFFFFFFF0, 1, 32'h0, 4'hF, 32'h0, 0, 1};
        vecs[5]  = '{enc(ST, 3'd2), 32'h40, 32'h12345678, 32'h0, 0, 0, 0, 0,
                     2, 0, 32'h0, 1, 32'h40, 4'hF, 32'h12345678, 1, 1};
        vecs[6]  = '{enc(LD, 3'd2), 32'h104, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0,
                     3, 0, 32'hDEADBEEF, 1, 32'h104, 4'hF, 32'h0, 0, 1};
        vecs[7]  = '{enc(ST, 3'd1), 32'h206, 32'h0000BEEF, 32'h0, 1, 0, 0, 0,
                     3, 0, 32'h0, 1, 32'h204, 4'b1100, 32'hBEEFBEEF, 1, 2};
        vecs[8]  = '{enc(LD, 3'd4), 32'h3, 32'h0, 32'h80FFFFFF, 0, 2, 0, 0,
                     4, 0, 32'h00000080, 1, 32'h0, 4'hF, 32'h0, 0, 1};
        vecs[9]  = '{enc(LD, 3'd0), 32'h1, 32'h0, 32'h00007F00, 2, 1, 0, 0,
                     5, 0, 32'h0000007F, 1, 32'h0, 4'hF, 32'h0, 0, 3};
        vecs[10] = '{enc(7'h33, 3'd0), 32'h10, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[11] = '{enc(LD, 3'd3), 32'h10, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[12] = '{enc(ST, 3'd4), 32'h10, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[13] = '{enc(ST, 3'd1), 32'h101, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[14] = '{enc(LD, 3'd1), 32'h8003, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0};
        vecs[15] = '{enc(LD, 3'd2), 32'h600, 32'h0, 32'h0, 0, 0, 0, 1,
                     6, 1, 32'h0, 1, 32'h600, 4'hF, 32'h0, 0, 1};
        vecs[16] = '{enc(ST, 3'd2), 32'h500, 32'h11223344, 32'h0, 0, 0, 1, 0,
                     5, 1, 32'h0, 1, 32'h500, 4'hF, 32'h11223344, 1, 4};

        rst            = 1'b1;
        bus.ex_valid   = 1'b0;
        bus.ex_instr   = '0;
        bus.ex_addr    = '0;
        bus.ex_wdata   = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) step();
        check("reset.ex_ready", bus.ex_ready, 1);
        check("reset.busy", busy, 0);
        check("reset.mem_req", bus.mem_req, 0);
        check("reset.mem_be", bus.mem_be, 0);
        check("reset.wb_valid", bus.wb_valid, 0);
        check("reset.wb_err", bus.wb_err, 0);
        check("reset.wb_data", bus.wb_data, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            v = vecs[i];
            do_op(v.instr, v.addr, v.wdata, v.rdata, v.gnt_dly, v.rv_dly, v.no_gnt, v.no_rv, r);
            verify($sformatf("vec%0d", i), v, r);
        end

        // Last vector timed out waiting for gnt; a late rvalid must not produce anything.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("late_rvalid%0d.wb_valid", i), bus.wb_valid, 0);
            check($sformatf("late_rvalid%0d.busy", i), busy, 0);
        end
        bus.mem_rvalid = 1'b0;
        step();

        // Reset while a load sits in WAIT.
        bus.ex_instr = enc(LD, 3'd2);
        bus.ex_addr  = 32'h700;
        bus.ex_valid = 1'b1;
        step();
        bus.ex_valid = 1'b0;
        check("rst_wait.req_cycle1", bus.mem_req, 1);
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        check("rst_wait.busy_in_wait", busy, 1);
        check("rst_wait.req_dropped", bus.mem_req, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wait.mem_req", bus.mem_req, 0);
        check("rst_wait.ex_ready", bus.ex_ready, 1);
        check("rst_wait.busy", busy, 0);
        check("rst_wait.wb_valid", bus.wb_valid, 0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_wait.stray_rvalid%0d", i), bus.wb_valid, 0);
        end
        bus.mem_rvalid = 1'b0;
        step();
        v = vecs[5];
        do_op(v.instr, v.addr, v.wdata, v.rdata, v.gnt_dly, v.rv_dly, v.no_gnt, v.no_rv, r);
        verify("after_reset", v, r);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] rnd, instr, addr;
            logic [6:0]  op;
            int          sel, gd, rd;
            rnd   = $urandom;
            sel   = $urandom_range(0, 9);
            op    = (sel < 5) ? LD : (sel < 9) ? ST : 7'($urandom);
            instr = {rnd[31:15], 3'($urandom), rnd[11:7], op};
            addr  = $urandom;
            gd    = $urandom_range(0, 3);
            rd    = $urandom_range(0, 3);
            v.instr   = instr;
            v.addr    = addr;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.gnt_dly = gd;
            v.rv_dly  = rd;
            v.no_gnt  = 0;
            v.no_rv   = 0;
            e = model(v.instr, v.addr, v.wdata, v.rdata);
            v.e_err   = e.err;
            v.e_data  = e.data;
            v.e_req   = !e.err;
            v.e_addr  = {addr[31:2], 2'b00};
            v.e_be    = e.be;
            v.e_wdata = e.wdata;
            v.e_we    = e.we;
            v.e_cyc   = e.err ? 1 : e.we ? gd + 2 : gd + rd + 2;
            v.e_reqc  = e.err ? 0 : gd + 1;
            do_op(v.instr, v.addr, v.wdata, v.rdata, v.gnt_dly, v.rv_dly, v.no_gnt, v.no_rv, r);
            verify($sformatf("rnd%0d", k), v, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit controller that sequences one RV32I data-memory access at a time between the execute stage and the data-memory port. It accepts a load or store over a valid/ready handshake and drives a req/gnt/rvalid memory handshake. Stores get byte enables and lane-replicated data; loads get lane extraction with sign or zero extension. Misaligned accesses, illegal encodings and memory timeouts return as an error on the writeback interface.

Parameters:
RSP_TIMEOUT, 255, cycles to wait in REQ (for gnt) or WAIT (for rvalid) before aborting with error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; RSP_TIMEOUT must fit in it.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  execute stage presents a memory op
ex_ready  out  1  controller accepts an op (high only in IDLE)
ex_instr  in  32  instruction; opcode [6:0], funct3 [14:12]
ex_addr  in  32  effective byte address
ex_wdata  in  32  store data (rs2)
mem_req  out  1  memory request
mem_gnt  in  1  memory accepts request
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_we  out  1  1 = store
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word
wb_valid  out  1  one-cycle completion pulse
wb_data  out  32  extended load result (0 for stores and errors)
wb_err  out  1  qualifies wb_valid: misaligned, illegal, or timeout
busy  out  1  state != IDLE

Behaviour:
- Reset (rst high at a clk edge): state IDLE, counter 0, all outputs 0 except ex_ready = 1. Reset aborts an access mid-flight and drops mem_req. An rvalid arriving in IDLE is ignored.
- The op is latched on ex_valid && ex_ready. Memory outputs are driven only from latched registers and are stable while mem_req is high.
- Legal encodings:
  - Opcode 0000011 (load): funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Opcode 0100011 (store): funct3 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned access: halfword ops with addr[0]=1; word ops with addr[1:0] != 0.
- Byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111. Loads drive mem_be = 1111.
- Store data: SB replicates byte ×4; SH replicates halfword ×2; SW passes the word through.
- Load extraction: shift mem_rdata right by 8*addr[1:0], take 8 or 16 bits, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → REQ on accept of a legal, aligned op.
  - IDLE → DONE with error latched on accept of an illegal or misaligned op; no memory request is issued.
  - REQ: mem_req = 1.
    - On gnt, a store → DONE.
    - On gnt, a load → WAIT. If rvalid is also high in the same cycle, the load captures data and goes directly → DONE.
    - rvalid without gnt is ignored.
  - WAIT: on rvalid, capture the extracted data → DONE.
  - DONE: wb_valid = 1 for exactly one cycle, then → IDLE. The next op can be accepted in the following cycle.
- Timeout: the counter clears on entry to REQ and to WAIT and increments each cycle without the awaited event. When it reaches RSP_TIMEOUT → DONE with wb_err = 1, mem_req dropped. A late rvalid is ignored.
- Latency with zero-wait memory (accept at cycle 0):
  - Store: mem_req in cycle 1, gnt in cycle 1, wb_valid in cycle 2.
  - Load: rvalid in cycle 2, wb_valid in cycle 3.
  - Error: wb_valid in cycle 1.

Decomposition:
- Package lsu_pkg holds:
  - opcode constants OP_LOAD and OP_STORE;
  - funct3 enum;
  - byte-enable base enum (SB=0001, SH=0011, SW=1111);
  - FSM state enum.
- Sub-module lsu_align is purely combinational: funct3 plus addr[1:0] in; mem_be, replicated wdata, extracted/extended load data, and misalign/illegal flags out.
- lsu_ctrl holds the FSM, the op latch, and the timeout counter.

Test Plan:
- SB addr 0x1003, wdata 0xAABBCC5A, gnt immediate → mem_be 1000, mem_wdata 0x5A5A5A5A, mem_addr 0x1000, wb_valid in cycle 2, wb_err 0.
- LH addr 0x2002, rdata 0x8001_1234, gnt+rvalid delayed 3 cycles → wb_data 0xFFFF8001. The same access as LHU → 0x00008001.
- LW addr 0x3001 → no mem_req, wb_valid in cycle 1, wb_err 1, wb_data 0.
- Load with gnt and rvalid in the same cycle, rdata 0x000000F0, LB addr 0x0 → skips WAIT, wb_data 0xFFFFFFF0 in cycle 2.
- RSP_TIMEOUT=4, gnt never asserted → mem_req falls after 4 REQ cycles, wb_err 1. A later rvalid is ignored.
- rst asserted while in WAIT → next cycle IDLE, mem_req 0, ex_ready 1, no wb_valid. A stray rvalid afterwards produces no output.
